cp0_timer_intc: RTL and testbench

- Parametrised successor to the CP0 Count/Compare timer and Cause.IP logic.
- Provides one free-running Count with a configurable prescaler and NUM_TIMERS compare channels, each with optional periodic auto-reload and its own enable.
- Synchronises the hardware interrupt lines, merges them with the software and timer sources, and produces a registered, prioritised interrupt request for the exception logic.
- Sits beside the CP0 register file, which routes mapped MTC0/MFC0 accesses here through a local CSR port.

---
 rtl/cp0_timer_intc_if.sv | 17 +
 rtl/cp0_timer_intc.sv | 181 ++++++++++++++++++
 tb/tb_cp0_timer_intc.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_timer_intc_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer_intc_if
// Description : Local CSR access port between the CP0 register file and the
//               timer / interrupt controller block.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_timer_intc_if;
    logic        csr_we;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (output csr_we, output csr_addr, output csr_wdata, input  csr_rdata);
    modport slave  (input  csr_we, input  csr_addr, input  csr_wdata, output csr_rdata);
endinterface
`default_nettype wire

// File: rtl/cp0_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer_intc
// Description : CP0 Count/Compare timer with NUM_TIMERS channels, hw_int
//               synchronisers and registered prioritised interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer_intc #(
    parameter int NUM_TIMERS  = 1,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_timer_intc_if.slave       csr,
    input  logic [5:0]            hw_int,
    input  logic                  count_stall,
    input  logic [7:0]            status_im,
    input  logic                  status_ie,
    input  logic                  status_exl,
    output logic [7:0]            cause_ip,
    output logic [NUM_TIMERS-1:0] timer_ip,
    output logic                  int_req,
    output logic [2:0]            int_num
);

    localparam logic [3:0] c_presc_max = 4'(COUNT_DIV - 1);

    logic [3:0]            r_presc;
    logic [31:0]           r_count;
    logic                  w_tick;
    logic                  w_count_we;
    logic [NUM_TIMERS-1:0] r_enable;
    logic [NUM_TIMERS-1:0] r_periodic;
    logic [1:0]            r_swip;
    logic [31:0]           r_compare [NUM_TIMERS];
    logic [31:0]           r_period  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_timer_ip;
    logic [NUM_TIMERS-1:0] r_match_q;
    logic [NUM_TIMERS-1:0] w_eq;
    logic [NUM_TIMERS-1:0] w_pulse;
    logic [NUM_TIMERS-1:0] w_cmp_we;
    logic [NUM_TIMERS-1:0] w_per_we;
    logic [5:0]            r_sync [SYNC_STAGES];
    logic [5:0]            w_hs;
    logic [7:0]            w_pend;
    logic [2:0]            w_num;
    logic [31:0]           w_rdata;

    assign w_tick     = ~count_stall && (r_presc == c_presc_max);
    assign w_count_we = csr.csr_we && (csr.csr_addr == 4'd0);

    // A CSR write to Count restarts the prescaler and overrides any tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (w_count_we) begin
            r_presc <= '0;
            r_count <= csr.csr_wdata;
        end else if (w_tick) begin
            r_presc <= '0;
            r_count <= r_count + 32'd1;
        end else if (!count_stall) begin
            r_presc <= r_presc + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable   <= '1;
            r_periodic <= '0;
            r_swip     <= '0;
        end else if (csr.csr_we) begin
            if (csr.csr_addr == 4'd1) begin
                r_enable   <= csr.csr_wdata[NUM_TIMERS-1:0];
                r_periodic <= csr.csr_wdata[8 +: NUM_TIMERS];
            end
            if (csr.csr_addr == 4'd2) begin
                r_swip <= csr.csr_wdata[1:0];
            end
        end
    end

    always_comb begin
        w_eq     = '0;
        w_pulse  = '0;
        w_cmp_we = '0;
        w_per_we = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_eq[i]     = (r_count == r_compare[i]) && r_enable[i];
            w_pulse[i]  = w_eq[i] && !r_match_q[i];
            w_cmp_we[i] = csr.csr_we && (csr.csr_addr == 4'(4 + i));
            w_per_we[i] = csr.csr_we && (csr.csr_addr == 4'(8 + i));
        end
    end

    // Edge-detecting the coincidence fires each channel once, however long Count dwells
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_ip <= '0;
            r_match_q  <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_compare[i] <= 32'hFFFF_FFFF;
                r_period[i]  <= '0;
            end
        end else begin
            r_match_q <= w_eq;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_cmp_we[i]) begin
                    r_compare[i]  <= csr.csr_wdata;
                    r_timer_ip[i] <= (csr.csr_wdata == r_count);
                end else if (w_pulse[i]) begin
                    r_timer_ip[i] <= 1'b1;
                    if (r_periodic[i]) begin
                        r_compare[i] <= r_compare[i] + r_period[i];
                    end
                end
                if (w_per_we[i]) begin
                    r_period[i] <= csr.csr_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_hs     = r_sync[SYNC_STAGES-1];
    assign cause_ip = {w_hs[5] | (|r_timer_ip), w_hs[4:0], r_swip};
    assign w_pend   = cause_ip & status_im;
    assign timer_ip = r_timer_ip;

    // Later iterations overwrite earlier ones, leaving the highest pending index
    always_comb begin
        w_num = '0;
        for (int b = 0; b < 8; b++) begin
            if (w_pend[b]) begin
                w_num = 3'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_req <= 1'b0;
            int_num <= '0;
        end else begin
            int_req <= status_ie && !status_exl && (|w_pend);
            int_num <= w_num;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (csr.csr_addr)
            4'd0:    w_rdata = r_count;
            4'd1:    w_rdata = (32'(r_periodic) << 8) | 32'(r_enable);
            4'd2:    w_rdata = {30'd0, r_swip};
            default: w_rdata = '0;
        endcase
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (csr.csr_addr == 4'(4 + i)) w_rdata = r_compare[i];
            if (csr.csr_addr == 4'(8 + i)) w_rdata = r_period[i];
        end
    end

    assign csr.csr_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_timer_intc
// Description : Self-checking bench for cp0_timer_intc against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_timer_intc;
    localparam int NT  = 2;
    localparam int DIV = 2;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    hw_int;
    logic          count_stall;
    logic [7:0]    status_im;
    logic          status_ie;
    logic          status_exl;
    logic [7:0]    cause_ip;
    logic [NT-1:0] timer_ip;
    logic          int_req;
    logic [2:0]    int_num;

    int checks = 0;
    int errors = 0;

    cp0_timer_intc_if csr_if ();

    cp0_timer_intc #(.NUM_TIMERS(NT), .COUNT_DIV(DIV), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .csr(csr_if), .hw_int(hw_int), .count_stall(count_stall),
        .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
        .cause_ip(cause_ip), .timer_ip(timer_ip), .int_req(int_req), .int_num(int_num)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_count;
    int          m_presc;
    logic [31:0] m_cmp [NT];
    logic [31:0] m_per [NT];
    logic [NT-1:0] m_en, m_perd, m_tip, m_mq;
    logic [1:0]  m_swip;
    logic [5:0]  m_sync [SS];
    logic        m_req;
    logic [2:0]  m_num;

    function automatic logic [7:0] m_cause();
        return {m_sync[SS-1][5] | (m_tip != '0), m_sync[SS-1][4:0], m_swip};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int ai = int'(a);
        if (ai == 0) return m_count;
        if (ai == 1) return (32'(m_perd) << 8) | 32'(m_en);
        if (ai == 2) return {30'd0, m_swip};
        if (ai >= 4 && ai < 4 + NT) return m_cmp[ai-4];
        if (ai >= 8 && ai < 8 + NT) return m_per[ai-8];
        return 32'd0;
    endfunction

    task automatic step();
        logic [31:0] n_count;
        int          n_presc;
        logic [31:0] n_cmp [NT];
        logic [31:0] n_per [NT];
        logic [NT-1:0] n_en, n_perd, n_tip, n_mq;
        logic [1:0]  n_swip;
        logic [5:0]  n_sync [SS];
        logic        n_req;
        logic [2:0]  n_num;
        logic [7:0]  pend;
        logic        eq;
        logic        we;
        int          a;
        logic [31:0] d;
        we = csr_if.csr_we; a = int'(csr_if.csr_addr); d = csr_if.csr_wdata;
        n_count = m_count; n_presc = m_presc; n_cmp = m_cmp; n_per = m_per;
        n_en = m_en; n_perd = m_perd; n_tip = m_tip; n_mq = m_mq; n_swip = m_swip;
        n_sync = m_sync; n_req = m_req; n_num = m_num;
        if (rst) begin
            n_count = 0; n_presc = 0; n_en = '1; n_perd = '0; n_tip = '0; n_mq = '0;
            n_swip = 0; n_req = 0; n_num = 0;
            for (int i = 0; i < NT; i++) begin n_cmp[i] = 32'hFFFF_FFFF; n_per[i] = 0; end
            for (int s = 0; s < SS; s++) n_sync[s] = 0;
        end else begin
            if (!count_stall) begin
                n_presc = (m_presc + 1) % DIV;
                if (n_presc == 0) n_count = m_count + 1;
            end
            if (we && a == 0) begin n_count = d; n_presc = 0; end
            for (int c = 0; c < NT; c++) begin
                eq = (m_count == m_cmp[c]) && m_en[c];
                n_mq[c] = eq;
                if (we && a == 4 + c) begin
                    n_cmp[c] = d;
                    n_tip[c] = (d == m_count);
                end else if (eq && !m_mq[c]) begin
                    n_tip[c] = 1'b1;
                    if (m_perd[c]) n_cmp[c] = m_cmp[c] + m_per[c];
                end
                if (we && a == 8 + c) n_per[c] = d;
            end
            if (we && a == 1) begin n_en = d[NT-1:0]; n_perd = d[8 +: NT]; end
            if (we && a == 2) n_swip = d[1:0];
            n_sync[0] = hw_int;
            for (int s = 1; s < SS; s++) n_sync[s] = m_sync[s-1];
            pend  = m_cause() & status_im;
            n_req = status_ie && !status_exl && (pend != 0);
            n_num = 0;
            for (int b = 7; b >= 0; b--) if (pend[b]) begin n_num = 3'(b); break; end
        end
        @(posedge clk); #1;
        m_count = n_count; m_presc = n_presc; m_cmp = n_cmp; m_per = n_per;
        m_en = n_en; m_perd = n_perd; m_tip = n_tip; m_mq = n_mq; m_swip = n_swip;
        m_sync = n_sync; m_req = n_req; m_num = n_num;
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_if.csr_we = 1'b1; csr_if.csr_addr = a; csr_if.csr_wdata = d;
        step();
        csr_if.csr_we = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a);
        csr_if.csr_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks += 5;
        if (cause_ip !== 8'h00) begin errors++; $display("FAIL reset_cause_ip: got %h want 00", cause_ip); end
        if (timer_ip !== '0) begin errors++; $display("FAIL reset_timer_ip: got %b want 0", timer_ip); end
        if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        if (int_num !== 3'd0) begin errors++; $display("FAIL reset_int_num: got %0d want 0", int_num); end
        peek(4'd0);
        if (csr_if.csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_count: got %h want 0", csr_if.csr_rdata); end
        checks += 3;
        peek(4'd4);
        if (csr_if.csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare0: got %h want FFFFFFFF", csr_if.csr_rdata); end
        peek(4'd1);
        if (csr_if.csr_rdata !== 32'h3) begin errors++; $display("FAIL reset_ctrl: got %h want 00000003", csr_if.csr_rdata); end
        peek(4'd9);
        if (csr_if.csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_period1: got %h want 0", csr_if.csr_rdata); end
    endtask

    task automatic test_timer_match();
        status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
        csr_write(4'd4, 32'd5);
        repeat (9) step();
        peek(4'd0);
        checks += 2;
        if (csr_if.csr_rdata !== 32'd5) begin errors++; $display("FAIL match_count: got %h want 5", csr_if.csr_rdata); end
        if (timer_ip[0] !== 1'b0) begin errors++; $display("FAIL match_early_ip: got %b want 0", timer_ip[0]); end
        step();
        checks += 3;
        if (timer_ip[0] !== 1'b1) begin errors++; $display("FAIL match_ip: got %b want 1", timer_ip[0]); end
        if (cause_ip[7] !== 1'b1) begin errors++; $display("FAIL match_cause7: got %b want 1", cause_ip[7]); end
        if (int_req !== 1'b0) begin errors++; $display("FAIL match_req_early: got %b want 0", int_req); end
        step();
        checks += 2;
        if (int_req !== 1'b1) begin errors++; $display("FAIL match_req: got %b want 1", int_req); end
        if (int_num !== 3'd7) begin errors++; $display("FAIL match_num: got %0d want 7", int_num); end
    endtask

    task automatic test_compare_write();
        int n;
        csr_write(4'd4, m_count + 32'd2);
        checks++;
        if (timer_ip[0] !== 1'b0) begin errors++; $display("FAIL cmpwr_clear: got %b want 0", timer_ip[0]); end
        n = 0;
        while (!(m_count == m_cmp[0] && m_en[0] && !m_mq[0]) && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL cmpwr_wait: got timeout want coincidence"); end
        csr_write(4'd4, 32'd100);
        checks++;
        if (timer_ip[0] !== 1'b0) begin errors++; $display("FAIL cmpwr_wins: got %b want 0", timer_ip[0]); end
        csr_write(4'd4, m_count);
        checks++;
        if (timer_ip[0] !== 1'b1) begin errors++; $display("FAIL cmpwr_equal: got %b want 1", timer_ip[0]); end
    endtask

    task automatic test_periodic();
        logic [31:0] exp_seq [3];
        logic [31:0] prev;
        int k;
        exp_seq[0] = 32'd7; exp_seq[1] = 32'd10; exp_seq[2] = 32'd13;
        csr_write(4'd1, 32'h101);
        csr_write(4'd8, 32'd3);
        csr_write(4'd0, 32'd0);
        csr_write(4'd4, 32'd4);
        peek(4'd4);
        prev = csr_if.csr_rdata;
        k = 0;
        for (int n = 0; n < 60 && k < 3; n++) begin
            step();
            if (csr_if.csr_rdata !== prev) begin
                checks++;
                if (csr_if.csr_rdata !== exp_seq[k]) begin
                    errors++; $display("FAIL periodic_reload%0d: got %0d want %0d", k, csr_if.csr_rdata, exp_seq[k]);
                end
                prev = csr_if.csr_rdata;
                k++;
            end
        end
        checks += 2;
        if (k != 3) begin errors++; $display("FAIL periodic_count: got %0d reloads want 3", k); end
        if (timer_ip[0] !== 1'b1) begin errors++; $display("FAIL periodic_ip: got %b want 1", timer_ip[0]); end
        csr_write(4'd1, 32'h3);
    endtask

    task automatic test_count_wrap();
        csr_write(4'd0, 32'hFFFF_FFFE);
        peek(4'd0);
        step(); step();
        checks++;
        if (csr_if.csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ff: got %h want FFFFFFFF", csr_if.csr_rdata); end
        step(); step();
        checks++;
        if (csr_if.csr_rdata !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h want 0", csr_if.csr_rdata); end
        step();
        count_stall = 1'b1;
        repeat (5) step();
        checks++;
        if (csr_if.csr_rdata !== 32'd0) begin errors++; $display("FAIL stall_hold: got %h want 0", csr_if.csr_rdata); end
        count_stall = 1'b0;
        step();
        checks++;
        if (csr_if.csr_rdata !== 32'd1) begin errors++; $display("FAIL stall_resume: got %h want 1", csr_if.csr_rdata); end
    endtask

    task automatic test_hw_int();
        status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
        hw_int = 6'b000100;
        step();
        checks++;
        if (cause_ip[4] !== 1'b0) begin errors++; $display("FAIL hw_sync_early: got %b want 0", cause_ip[4]); end
        step();
        checks += 2;
        if (cause_ip[4] !== 1'b1) begin errors++; $display("FAIL hw_cause4: got %b want 1", cause_ip[4]); end
        if (int_req !== 1'b0) begin errors++; $display("FAIL hw_req_early: got %b want 0", int_req); end
        step();
        checks += 2;
        if (int_req !== 1'b1) begin errors++; $display("FAIL hw_req: got %b want 1", int_req); end
        if (int_num !== 3'd4) begin errors++; $display("FAIL hw_num: got %0d want 4", int_num); end
        status_exl = 1'b1;
        step();
        checks++;
        if (int_req !== 1'b0) begin errors++; $display("FAIL hw_exl: got %b want 0", int_req); end
        status_exl = 1'b0;
        hw_int = 6'd0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 1500; it++) begin
            rst = ($urandom_range(0, 199) == 0);
            csr_if.csr_we   = ($urandom_range(0, 2) == 0);
            csr_if.csr_addr = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       csr_if.csr_wdata = $urandom;
                1:       csr_if.csr_wdata = m_count + 32'($urandom_range(0, 6));
                default: csr_if.csr_wdata = 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            count_stall = ($urandom_range(0, 7) == 0);
            status_im   = 8'($urandom);
            status_ie   = ($urandom_range(0, 3) != 0);
            status_exl  = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (csr_if.csr_rdata !== m_read(csr_if.csr_addr)) begin
                errors++; $display("FAIL rand_rdata[%0d] addr %0d: got %h want %h", it, csr_if.csr_addr, csr_if.csr_rdata, m_read(csr_if.csr_addr));
            end
            step();
            checks += 4;
            if (cause_ip !== m_cause()) begin errors++; $display("FAIL rand_cause[%0d]: got %h want %h", it, cause_ip, m_cause()); end
            if (timer_ip !== m_tip) begin errors++; $display("FAIL rand_timer_ip[%0d]: got %b want %b", it, timer_ip, m_tip); end
            if (int_req !== m_req) begin errors++; $display("FAIL rand_int_req[%0d]: got %b want %b", it, int_req, m_req); end
            if (int_num !== m_num) begin errors++; $display("FAIL rand_int_num[%0d]: got %0d want %0d", it, int_num, m_num); end
        end
        rst = 1'b0; csr_if.csr_we = 1'b0; count_stall = 1'b0; status_exl = 1'b0;
    endtask

    task automatic test_reset_mid();
        csr_write(4'd4, m_count);
        hw_int = 6'h3F;
        repeat (3) step();
        checks++;
        if (timer_ip[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ip: got %b want 1", timer_ip[0]); end
        rst = 1'b1;
        step();
        checks += 4;
        if (cause_ip !== 8'h00) begin errors++; $display("FAIL rstmid_cause: got %h want 00", cause_ip); end
        if (timer_ip !== '0) begin errors++; $display("FAIL rstmid_timer_ip: got %b want 0", timer_ip); end
        if (int_req !== 1'b0) begin errors++; $display("FAIL rstmid_int_req: got %b want 0", int_req); end
        if (int_num !== 3'd0) begin errors++; $display("FAIL rstmid_int_num: got %0d want 0", int_num); end
        peek(4'd4);
        checks++;
        if (csr_if.csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_compare0: got %h want FFFFFFFF", csr_if.csr_rdata); end
        rst = 1'b0;
        hw_int = 6'd0;
    endtask

    initial begin
        rst = 1'b1; hw_int = '0; count_stall = 1'b0;
        status_im = '0; status_ie = 1'b0; status_exl = 1'b0;
        csr_if.csr_we = 1'b0; csr_if.csr_addr = '0; csr_if.csr_wdata = '0;
        m_count = '0; m_presc = 0; m_en = '1; m_perd = '0; m_tip = '0; m_mq = '0;
        m_swip = '0; m_req = 1'b0; m_num = '0;
        for (int i = 0; i < NT; i++) begin m_cmp[i] = 32'hFFFF_FFFF; m_per[i] = '0; end
        for (int s = 0; s < SS; s++) m_sync[s] = '0;
        #1;
        test_reset();
        test_timer_match();
        test_compare_write();
        test_periodic();
        test_count_wrap();
        test_hw_int();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
